// File: rtl/fetch_queue_pkg.sv
// Shared types and default sizes for the fetch-to-decode instruction queue.
package fetch_queue_pkg;

  // Size of the upstream uop buffer that feeds the fetch stage.
  localparam int UOP_BUF_SIZE = 16;

  // Default number of single-instruction entries in the fetch queue.
  localparam int QUEUE_DEPTH_DEFAULT = 8;

  // One fetched instruction as handed from fetch to decode.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetched_instruction;

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue.sv
// 2-wide in / 2-wide out circular instruction queue between fetch and decode.
// Stall is derived from the registered occupancy only, so it never depends
// combinationally on the downstream stall or the upstream valids.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           prev_valid,
  input  logic                           prev_valid_2,
  input  fetched_instruction             instruction_1_in,
  input  fetched_instruction             instruction_2_in,
  output logic                           stalled,
  input  logic                           next_stalled,
  output logic                           valid,
  output logic                           valid_2,
  output fetched_instruction             instruction_1,
  output fetched_instruction             instruction_2,
  output logic [$clog2(QUEUE_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   head_plus1;
  logic [PTR_W-1:0]   tail_plus1;
  logic               enq;
  logic               enq_two;
  logic [CNT_W-1:0]   enq_n;
  logic [CNT_W-1:0]   deq_n;
  logic               flush;

  fetched_instruction mem_q [QUEUE_DEPTH];

  // Pointers are power-of-two wide, so natural overflow gives the modulo wrap.
  assign head_plus1 = head_q + PTR_W'(1);
  assign tail_plus1 = tail_q + PTR_W'(1);

  // Stall while fewer than two free slots remain, even if decode drains this
  // cycle; this keeps the upstream handshake free of combinational paths.
  assign stalled = (count_q > CNT_W'(QUEUE_DEPTH - 2));
  assign valid   = (count_q != '0);
  assign valid_2 = (count_q >= CNT_W'(2));
  assign count   = count_q;

  assign instruction_1 = mem_q[head_q];
  assign instruction_2 = mem_q[head_plus1];

  assign flush   = reset || clear;
  assign enq     = prev_valid && !stalled;
  assign enq_two = enq && prev_valid_2;
  assign enq_n   = enq ? (enq_two ? CNT_W'(2) : CNT_W'(1)) : '0;
  assign deq_n   = next_stalled ? '0 : (CNT_W'(valid) + CNT_W'(valid_2));

  // Next-state for pointers and occupancy; a flush discards any same-cycle traffic.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(deq_n);
      tail_d  = tail_q + PTR_W'(enq_n);
      count_d = count_q + enq_n - deq_n;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    head_q  <= head_d;
    tail_q  <= tail_d;
    count_q <= count_d;
  end

  // Storage writes; contents are deliberately not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (!flush && enq) begin
      mem_q[tail_q] <= instruction_1_in;
      if (enq_two) begin
        mem_q[tail_plus1] <= instruction_2_in;
      end
    end
  end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic,
// compared against a queue-based reference model of the occupancy rules.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic               clk;
  logic               reset;
  logic               clear;
  logic               prev_valid;
  logic               prev_valid_2;
  fetched_instruction instruction_1_in;
  fetched_instruction instruction_2_in;
  logic               stalled;
  logic               next_stalled;
  logic               valid;
  logic               valid_2;
  fetched_instruction instruction_1;
  fetched_instruction instruction_2;
  logic [CW-1:0]      count;

  int checks = 0;
  int errors = 0;
  int seq    = 0;
  fetched_instruction model_q[$];

  fetch_queue #(.QUEUE_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .clear            (clear),
    .prev_valid       (prev_valid),
    .prev_valid_2     (prev_valid_2),
    .instruction_1_in (instruction_1_in),
    .instruction_2_in (instruction_2_in),
    .stalled          (stalled),
    .next_stalled     (next_stalled),
    .valid            (valid),
    .valid_2          (valid_2),
    .instruction_1    (instruction_1),
    .instruction_2    (instruction_2),
    .count            (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic fetched_instruction make_instr();
    fetched_instruction f;
    seq    = seq + 1;
    f.pc   = 32'(seq) << 2;
    f.insn = $urandom;
    return f;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Compare every observable output against the model queue.
  task automatic check_all(input string tag);
    int sz;
    sz = model_q.size();
    checks++;
    assert (count === CW'(sz)) else begin
      errors++;
      $error("FAIL %s.count observed=%0d expected=%0d", tag, count, sz);
    end
    check_bit({tag, ".stalled"}, stalled, (DEPTH - sz) < 2);
    check_bit({tag, ".valid"}, valid, sz >= 1);
    check_bit({tag, ".valid_2"}, valid_2, sz >= 2);
    if (sz >= 1) begin
      checks++;
      assert (instruction_1 === model_q[0]) else begin
        errors++;
        $error("FAIL %s.instr1 observed=%h expected=%h", tag, instruction_1, model_q[0]);
      end
    end
    if (sz >= 2) begin
      checks++;
      assert (instruction_2 === model_q[1]) else begin
        errors++;
        $error("FAIL %s.instr2 observed=%h expected=%h", tag, instruction_2, model_q[1]);
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model by the spec rules, then check.
  task automatic step(input string tag, input logic rst, input logic clr,
                      input logic pv, input logic pv2, input logic ns);
    int sz;
    int n;
    fetched_instruction a;
    fetched_instruction b;
    a = make_instr();
    b = make_instr();
    reset            = rst;
    clear            = clr;
    prev_valid       = pv;
    prev_valid_2     = pv2;
    next_stalled     = ns;
    instruction_1_in = a;
    instruction_2_in = b;
    sz = model_q.size();
    if (rst || clr) begin
      model_q.delete();
    end else begin
      n = ns ? 0 : ((sz >= 2) ? 2 : sz);
      for (int i = 0; i < n; i++) void'(model_q.pop_front());
      if (pv && (DEPTH - sz) >= 2) begin
        model_q.push_back(a);
        if (pv2) model_q.push_back(b);
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
    $display("step %-8s rst=%0b clr=%0b pv=%0b pv2=%0b ns=%0b -> count=%0d stalled=%0b v=%0b v2=%0b",
             tag, rst, clr, pv, pv2, ns, count, stalled, valid, valid_2);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; prev_valid = 1'b0; prev_valid_2 = 1'b0;
    next_stalled = 1'b0; instruction_1_in = '0; instruction_2_in = '0;

    // Reset state.
    step("reset", 1, 0, 0, 0, 0);
    step("reset", 1, 0, 0, 0, 0);

    // Pair A,B then drain.
    step("pairAB", 0, 0, 1, 1, 0);
    step("drainAB", 0, 0, 0, 0, 0);
    // Single C then drain.
    step("singleC", 0, 0, 1, 0, 0);
    step("drainC", 0, 0, 0, 0, 0);

    // Fill with decode stalled until the queue stalls upstream; hold there.
    for (int i = 0; i < 6; i++) step("fill", 0, 0, 1, 1, 1);

    // Odd occupancy: drain, then 1 + pairs to reach 7, then release decode.
    for (int i = 0; i < 5; i++) step("drain", 0, 0, 0, 0, 0);
    step("odd1", 0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) step("odd", 0, 0, 1, 1, 1);
    for (int i = 0; i < 5; i++) step("release", 0, 0, 0, 0, 0);

    // Random traffic wraps head and tail many times; occasional flushes.
    for (int i = 0; i < 300; i++) begin
      step("rand", 0, ($urandom_range(0, 40) == 0), $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
    end

    // count=5 then a pair arriving together with clear: the pair is discarded.
    step("pre_clr", 0, 1, 0, 0, 0);
    step("c5a", 0, 0, 1, 0, 1);
    step("c5b", 0, 0, 1, 1, 1);
    step("c5c", 0, 0, 1, 1, 1);
    step("clear", 0, 1, 1, 1, 0);
    step("postclr", 0, 0, 0, 0, 0);
    step("after", 0, 0, 1, 1, 0);
    step("after2", 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_queue
